branch_target_unit: RTL and testbench

- Produces the `jump_en` / `target` pair consumed by the program counter.
- Consumes the current `prog_ctr`, a decoded branch opcode, a LUT index and the ALU zero flag.
- Holds a programmable branch-target lookup table (LUT) and a small return-address stack, so absolute jumps, conditional branches, calls and returns all resolve in the cycle the instruction is fetched.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_target_unit_ret_stack.sv | 90 +++++++++
 rtl/branch_target_unit.sv | 133 +++++++++++++
 tb/tb_branch_target_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types for the branch target unit.
//               BR_OP_W  - width of the decoded branch opcode
//               br_op_t  - decoded branch opcode encoding
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam int BR_OP_W = 3;

    // Codes 6 and 7 are reserved and decode as BR_NONE.
    typedef enum logic [BR_OP_W-1:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_BZ   = 3'd2,
        BR_BNZ  = 3'd3,
        BR_CALL = 3'd4,
        BR_RET  = 3'd5
    } br_op_t;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_target_unit_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : Return-address stack of SD entries, each D bits wide.
//               The top entry is readable combinationally. Sticky overflow
//               and underflow flags record rejected pushes and pops.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               push, push_data - push request and the address to store
//               pop             - pop request
//               top             - current top entry (0 when empty)
//               count           - occupancy, 0..SD
//               full, empty     - occupancy status
//               ovf, udf        - sticky: push while full / pop while empty
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
    import branch_pkg::*;
#(
    parameter int SD = 4,
    parameter int D  = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [D-1:0]             push_data,
    output logic [D-1:0]             top,
    output logic [$clog2(SD+1)-1:0]  count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     udf
);

    localparam int CW = $clog2(SD + 1);
    localparam int PW = $clog2(SD);

    logic [D-1:0]  r_mem [SD];
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_udf;

    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_top_ptr;

    assign w_full    = (r_count == CW'(SD));
    assign w_empty   = (r_count == '0);
    // Occupancy is below SD whenever a write happens, so the low bits
    // address the next free slot directly.
    assign w_wr_ptr  = r_count[PW-1:0];
    assign w_top_ptr = PW'(r_count - CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SD; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (push) begin
                if (w_full) begin
                    // Dropped push: contents and occupancy stay untouched.
                    r_ovf <= 1'b1;
                end else begin
                    r_mem[w_wr_ptr] <= push_data;
                    r_count         <= r_count + CW'(1);
                end
            end else if (pop) begin
                if (w_empty) begin
                    r_udf <= 1'b1;
                end else begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    assign top   = w_empty ? '0 : r_mem[w_top_ptr];
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule : ret_stack
`default_nettype wire

// File: rtl/branch_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_unit
// Description : Resolves jumps, conditional branches, calls and returns in
//               the fetch cycle. Targets come from a programmable lookup
//               table or from the top of a return-address stack.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               prog_ctr          - address of the current instruction
//               br_op             - decoded branch opcode (br_op_t)
//               lut_idx           - LUT entry selected by the instruction
//               zero_flag         - ALU zero flag
//               lut_wr_en/idx/data- LUT write port
//               jump_en, target   - PC load strobe and destination
//               stk_count         - return-stack occupancy
//               stk_ovf, stk_udf  - sticky stack overflow / underflow
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_unit
    import branch_pkg::*;
#(
    parameter int D  = 12,
    parameter int LW = 5,
    parameter int SD = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [D-1:0]             prog_ctr,
    input  logic [BR_OP_W-1:0]       br_op,
    input  logic [LW-1:0]            lut_idx,
    input  logic                     zero_flag,
    input  logic                     lut_wr_en,
    input  logic [LW-1:0]            lut_wr_idx,
    input  logic [D-1:0]             lut_wr_data,
    output logic                     jump_en,
    output logic [D-1:0]             target,
    output logic [$clog2(SD+1)-1:0]  stk_count,
    output logic                     stk_ovf,
    output logic                     stk_udf
);

    localparam int LUT_N = 2 ** LW;

    logic [D-1:0] r_lut [LUT_N];

    logic [D-1:0] w_lut_rd;
    logic [D-1:0] w_ret_addr;
    logic [D-1:0] w_stk_top;
    logic         w_stk_empty;
    logic         w_unused_full;
    logic         w_push;
    logic         w_pop;
    logic         w_jump;
    logic [D-1:0] w_tgt;
    logic         w_jump_gated;

    // LUT: a same-cycle read of the written index sees the old value,
    // because the read is combinational off the registered array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                r_lut[i] <= '0;
            end
        end else if (lut_wr_en) begin
            r_lut[lut_wr_idx] <= lut_wr_data;
        end
    end

    assign w_lut_rd   = r_lut[lut_idx];
    // Natural D-bit wrap: the last address returns to 0.
    assign w_ret_addr = prog_ctr + D'(1);

    ret_stack #(
        .SD (SD),
        .D  (D)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_ret_addr),
        .top       (w_stk_top),
        .count     (stk_count),
        .full      (w_unused_full),
        .empty     (w_stk_empty),
        .ovf       (stk_ovf),
        .udf       (stk_udf)
    );

    always_comb begin
        w_jump = 1'b0;
        w_tgt  = '0;
        w_push = 1'b0;
        w_pop  = 1'b0;
        case (br_op)
            BR_JMP: begin
                w_jump = 1'b1;
                w_tgt  = w_lut_rd;
            end
            BR_BZ: begin
                w_jump = zero_flag;
                w_tgt  = w_lut_rd;
            end
            BR_BNZ: begin
                w_jump = ~zero_flag;
                w_tgt  = w_lut_rd;
            end
            BR_CALL: begin
                // The call is taken even when the push gets dropped.
                w_jump = 1'b1;
                w_tgt  = w_lut_rd;
                w_push = 1'b1;
            end
            BR_RET: begin
                w_pop = 1'b1;
                if (!w_stk_empty) begin
                    w_jump = 1'b1;
                    w_tgt  = w_stk_top;
                end
            end
            default: begin
                w_jump = 1'b0;
            end
        endcase
    end

    // Target is forced to zero whenever no jump is requested, and both
    // outputs are held low throughout reset.
    assign w_jump_gated = w_jump & ~reset;
    assign jump_en      = w_jump_gated;
    assign target       = w_jump_gated ? w_tgt : '0;

endmodule : branch_target_unit
`default_nettype wire

// File: tb/tb_branch_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_unit
// Description : Directed self-checking bench for branch_target_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_unit;
    import branch_pkg::*;

    localparam int D  = 12;
    localparam int LW = 5;
    localparam int SD = 4;
    localparam int CW = $clog2(SD + 1);

    logic                clk;
    logic                reset;
    logic [D-1:0]        prog_ctr;
    logic [BR_OP_W-1:0]  br_op;
    logic [LW-1:0]       lut_idx;
    logic                zero_flag;
    logic                lut_wr_en;
    logic [LW-1:0]       lut_wr_idx;
    logic [D-1:0]        lut_wr_data;
    logic                jump_en;
    logic [D-1:0]        target;
    logic [CW-1:0]       stk_count;
    logic                stk_ovf;
    logic                stk_udf;

    int n_tests;
    int n_fail;

    branch_target_unit #(
        .D  (D),
        .LW (LW),
        .SD (SD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_ctr    (prog_ctr),
        .br_op       (br_op),
        .lut_idx     (lut_idx),
        .zero_flag   (zero_flag),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .jump_en     (jump_en),
        .target      (target),
        .stk_count   (stk_count),
        .stk_ovf     (stk_ovf),
        .stk_udf     (stk_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [LW-1:0] idx,
                         input logic z, input logic [D-1:0] pc);
        br_op     = op;
        lut_idx   = idx;
        zero_flag = z;
        prog_ctr  = pc;
        #1;
    endtask

    task automatic lut_write(input logic [LW-1:0] idx, input logic [D-1:0] data);
        lut_wr_en   = 1'b1;
        lut_wr_idx  = idx;
        lut_wr_data = data;
        tick();
        lut_wr_en   = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        prog_ctr    = '0;
        br_op       = BR_JMP;
        lut_idx     = 5'd3;
        zero_flag   = 1'b0;
        lut_wr_en   = 1'b0;
        lut_wr_idx  = '0;
        lut_wr_data = '0;
        #2;
        chk("rst_jump_en",   32'(jump_en),   32'd0);
        chk("rst_target",    32'(target),    32'd0);
        chk("rst_stk_count", 32'(stk_count), 32'd0);
        chk("rst_ovf",       32'(stk_ovf),   32'd0);
        chk("rst_udf",       32'(stk_udf),   32'd0);
        tick();
        reset = 1'b0;
        drive(BR_JMP, 5'd3, 1'b0, 12'h000);
        chk("lut3_reset_jump", 32'(jump_en), 32'd1);
        chk("lut3_reset_val",  32'(target),  32'h000);

        // Load and jump
        drive(BR_NONE, 5'd3, 1'b0, 12'h000);
        chk("none_jump", 32'(jump_en), 32'd0);
        lut_write(5'd3, 12'h0A5);
        drive(BR_JMP, 5'd3, 1'b0, 12'h000);
        chk("jmp_jump",   32'(jump_en), 32'd1);
        chk("jmp_target", 32'(target),  32'h0A5);

        // Conditional branches
        drive(BR_NONE, 5'd0, 1'b0, 12'h000);
        lut_write(5'd7, 12'h040);
        drive(BR_BZ, 5'd7, 1'b1, 12'h000);
        chk("bz_t_jump",   32'(jump_en), 32'd1);
        chk("bz_t_target", 32'(target),  32'h040);
        drive(BR_BZ, 5'd7, 1'b0, 12'h000);
        chk("bz_nt_jump",   32'(jump_en), 32'd0);
        chk("bz_nt_target", 32'(target),  32'h000);
        drive(BR_BNZ, 5'd7, 1'b0, 12'h000);
        chk("bnz_t_jump",   32'(jump_en), 32'd1);
        chk("bnz_t_target", 32'(target),  32'h040);
        drive(BR_BNZ, 5'd7, 1'b1, 12'h000);
        chk("bnz_nt_jump",   32'(jump_en), 32'd0);
        chk("bnz_nt_target", 32'(target),  32'h000);
        drive(3'd6, 5'd7, 1'b1, 12'h000);
        chk("rsv6_jump",   32'(jump_en), 32'd0);
        chk("rsv6_target", 32'(target),  32'h000);
        drive(3'd7, 5'd3, 1'b0, 12'h000);
        chk("rsv7_jump", 32'(jump_en), 32'd0);

        // Call / return
        drive(BR_CALL, 5'd3, 1'b0, 12'h010);
        chk("call_jump",   32'(jump_en), 32'd1);
        chk("call_target", 32'(target),  32'h0A5);
        tick();
        chk("call_count", 32'(stk_count), 32'd1);
        drive(BR_RET, 5'd0, 1'b0, 12'h0A5);
        chk("ret_jump",   32'(jump_en), 32'd1);
        chk("ret_target", 32'(target),  32'h011);
        tick();
        chk("ret_count", 32'(stk_count), 32'd0);

        // Return-address wrap
        drive(BR_CALL, 5'd3, 1'b0, 12'hFFF);
        tick();
        drive(BR_RET, 5'd0, 1'b0, 12'h0A5);
        chk("wrap_jump",   32'(jump_en), 32'd1);
        chk("wrap_target", 32'(target),  32'h000);
        tick();

        // Overflow: four pushes fill the stack, the fifth is dropped
        for (int i = 0; i < 5; i++) begin
            drive(BR_CALL, 5'd3, 1'b0, 12'(12'h100 + i));
            chk("ovf_call_jump", 32'(jump_en), 32'd1);
            tick();
        end
        chk("ovf_count", 32'(stk_count), 32'd4);
        chk("ovf_flag",  32'(stk_ovf),   32'd1);
        chk("ovf_no_udf", 32'(stk_udf),  32'd0);

        // LIFO pops: 104, 103, 102, 101
        for (int i = 0; i < 4; i++) begin
            drive(BR_RET, 5'd0, 1'b0, 12'h200);
            chk("lifo_jump",   32'(jump_en), 32'd1);
            chk("lifo_target", 32'(target),  32'(12'h104 - i));
            tick();
        end
        chk("lifo_count", 32'(stk_count), 32'd0);
        drive(BR_RET, 5'd0, 1'b0, 12'h200);
        chk("udf_jump",   32'(jump_en), 32'd0);
        chk("udf_target", 32'(target),  32'h000);
        tick();
        chk("udf_flag",      32'(stk_udf),   32'd1);
        chk("udf_count",     32'(stk_count), 32'd0);
        chk("ovf_sticky",    32'(stk_ovf),   32'd1);

        // Same-cycle LUT write/read
        drive(BR_NONE, 5'd0, 1'b0, 12'h000);
        lut_write(5'd2, 12'h100);
        drive(BR_JMP, 5'd2, 1'b0, 12'h000);
        lut_wr_en   = 1'b1;
        lut_wr_idx  = 5'd2;
        lut_wr_data = 12'h200;
        #1;
        chk("wr_rd_old", 32'(target), 32'h100);
        tick();
        lut_wr_en = 1'b0;
        #1;
        chk("wr_rd_new", 32'(target), 32'h200);

        // Reset mid-operation with a pending call
        drive(BR_CALL, 5'd3, 1'b0, 12'h050);
        chk("mid_call_jump", 32'(jump_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_jump",   32'(jump_en),   32'd0);
        chk("mid_rst_target", 32'(target),    32'h000);
        chk("mid_rst_udf",    32'(stk_udf),   32'd0);
        chk("mid_rst_ovf",    32'(stk_ovf),   32'd0);
        tick();
        reset = 1'b0;
        drive(BR_RET, 5'd0, 1'b0, 12'h000);
        chk("post_rst_count",   32'(stk_count), 32'd0);
        chk("post_rst_ret",     32'(jump_en),   32'd0);
        drive(BR_JMP, 5'd3, 1'b0, 12'h000);
        chk("post_rst_lut3",    32'(target),    32'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_branch_target_unit
`default_nettype wire
